tristate_bus_responder: RTL and testbench

//  Responder end of the shared tristate data bus. The initiator drives dq with a

---
 rtl/tristate_bus_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_tristate_bus_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tristate_bus_responder
// Description : Responder end of a shared tristate data bus.
//               The initiator drives a command strobe together with the
//               command type. Writes carry their data on dq in the same
//               cycle and are captured into an RX FIFO that a local
//               consumer drains. Reads make the responder drive dq after a
//               configurable turnaround gap. The read returns the word held
//               in a single-entry TX buffer, or an error response of zero
//               when that buffer is empty.
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               dq                    shared bus, driven only in DRIVE
//               cmd_valid, cmd_rd     initiator command strobe / read select
//               rsp_valid, rsp_err    read response qualifiers
//               rx_data, rx_valid,
//               rx_ready              RX FIFO consumer side
//               tx_data, tx_valid,
//               tx_ready              TX buffer load side
//               overflow, proto_err,
//               clr_flags             sticky error flags and their clear
// Revision    : 1.0 - initial release
// ============================================================================
module tristate_bus_responder #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int TURNAROUND = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] dq,
    input  logic             cmd_valid,
    input  logic             cmd_rd,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             overflow,
    output logic             proto_err,
    input  logic             clr_flags
);

    localparam int              C_ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              C_CNT_W     = C_ADDR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH_CNT = C_CNT_W'(DEPTH);
    // Turnaround counter preload; a zero turnaround never enters TURN.
    localparam logic [3:0]      C_TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_oe;
    logic                r_rsp_err;
    logic [WIDTH-1:0]    r_rsp_data;
    logic                r_tx_full;
    logic [WIDTH-1:0]    r_tx_buf;
    logic [C_ADDR_W-1:0] r_wr_ptr;
    logic [C_ADDR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0]  r_count;
    logic                r_overflow;
    logic                r_proto_err;
    logic [WIDTH-1:0]    r_mem [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [3:0]          w_cnt_nxt;
    logic                w_enter_drive;
    logic                w_wr;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_proto;
    logic                w_tx_load;

    // Next-state logic for the bus turnaround sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && cmd_rd) begin
                    if (TURNAROUND == 0) begin
                        w_state_nxt = ST_DRIVE;
                    end else begin
                        w_state_nxt = ST_TURN;
                        w_cnt_nxt   = C_TURN_LOAD;
                    end
                end
            end
            ST_TURN: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_DRIVE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_DRIVE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath strobes. Fullness and TX occupancy are the values before the
    // edge, so a write while full is dropped even with a concurrent pop, and a
    // TX load can only land while the buffer is empty.
    always_comb begin
        w_enter_drive = (w_state_nxt == ST_DRIVE);
        w_wr          = (r_state == ST_IDLE) && cmd_valid && !cmd_rd;
        w_full        = (r_count == C_DEPTH_CNT);
        w_push        = w_wr && !w_full;
        w_drop        = w_wr && w_full;
        w_pop         = rx_valid && rx_ready;
        w_proto       = cmd_valid && (r_state != ST_IDLE);
        w_tx_load     = tx_valid && !r_tx_full;
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_oe        <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_tx_full   <= 1'b0;
            r_tx_buf    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;

            // Output enable is a registered decode of the DRIVE state, so
            // nothing on the command inputs reaches dq combinationally.
            r_oe      <= w_enter_drive;
            r_rsp_err <= w_enter_drive && !r_tx_full;
            if (w_enter_drive) begin
                r_rsp_data <= r_tx_full ? r_tx_buf : '0;
            end

            // A load and a drain of the TX buffer are mutually exclusive:
            // a load needs the buffer empty, a drain needs it full. A load
            // that coincides with an error response is kept for the next read.
            if (w_tx_load) begin
                r_tx_full <= 1'b1;
                r_tx_buf  <= tx_data;
            end else if (w_enter_drive) begin
                r_tx_full <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A fresh error on the clearing edge keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_proto) begin
                r_proto_err <= 1'b1;
            end else if (clr_flags) begin
                r_proto_err <= 1'b0;
            end
        end
    end

    // FIFO storage carries no reset; its contents are only observed through
    // rx_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dq;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign dq        = r_oe ? r_rsp_data : {WIDTH{1'bz}};
    assign rsp_valid = r_oe;
    assign rsp_err   = r_rsp_err;
    assign rx_data   = r_mem[r_rd_ptr];
    assign rx_valid  = (r_count != '0);
    assign tx_ready  = !r_tx_full;
    assign overflow  = r_overflow;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tristate_bus_responder
// Description : Directed self-checking bench for tristate_bus_responder.
//               Two responders share every input except the bus: one with a
//               turnaround of one cycle, one with no turnaround. Each has its
//               own dq net with weak pull-ups, so a released bus reads as
//               all ones (or z). Expected FIFO words and read responses are
//               queued when stimulus is applied and popped when the
//               responders present them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tristate_bus_responder;

    localparam int C_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rd = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       clr_flags = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       drv_oe = 1'b0;

    wire  [7:0] dq_a;
    wire  [7:0] dq_b;
    logic       a_rsp_valid, a_rsp_err, a_rx_valid, a_tx_ready, a_overflow, a_proto_err;
    logic       b_rsp_valid, b_rsp_err, b_rx_valid, b_tx_ready, b_overflow, b_proto_err;
    logic [7:0] a_rx_data, b_rx_data;

    always #5 clk = ~clk;

    assign dq_a = drv_oe ? drv_data : 8'hzz;
    assign dq_b = drv_oe ? drv_data : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (dq_a[g]);
        pullup (dq_b[g]);
    end

    tristate_bus_responder #(.WIDTH(8), .DEPTH(C_DEPTH), .TURNAROUND(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .dq(dq_a),
        .cmd_valid(cmd_valid), .cmd_rd(cmd_rd),
        .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(a_tx_ready),
        .overflow(a_overflow), .proto_err(a_proto_err), .clr_flags(clr_flags)
    );

    tristate_bus_responder #(.WIDTH(8), .DEPTH(C_DEPTH), .TURNAROUND(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .dq(dq_b),
        .cmd_valid(cmd_valid), .cmd_rd(cmd_rd),
        .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(b_tx_ready),
        .overflow(b_overflow), .proto_err(b_proto_err), .clr_flags(clr_flags)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] rx_q[$];
    logic [8:0] rsp_qa[$];
    logic [8:0] rsp_qb[$];
    logic       tx_full_m = 1'b0;
    logic [7:0] tx_data_m = 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rel(input string tag, input logic [7:0] v);
        vectors++;
        assert (v === 8'hzz || v === 8'hff) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=released", tag, v);
        end
    endtask

    task automatic load_tx(input logic [7:0] d);
        chk("tx_ready_before_load", a_tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid  = 1'b0;
        tx_full_m = 1'b1;
        tx_data_m = d;
        chk("tx_ready_after_load", a_tx_ready, 0);
    endtask

    task automatic do_write(input logic [7:0] d, input bit pop, input bit clr);
        logic [7:0] head;
        bit         drop;
        drop = (rx_q.size() >= C_DEPTH);
        if (pop) begin
            head = rx_q.pop_front();
            chk("pop_head_a", a_rx_data, head);
            chk("pop_head_b", b_rx_data, head);
        end
        if (!drop) rx_q.push_back(d);
        drv_oe    = 1'b1;
        drv_data  = d;
        cmd_valid = 1'b1;
        cmd_rd    = 1'b0;
        rx_ready  = pop;
        clr_flags = clr;
        tick();
        drv_oe    = 1'b0;
        cmd_valid = 1'b0;
        rx_ready  = 1'b0;
        clr_flags = 1'b0;
        chk("rx_valid_after_wr", a_rx_valid, 1);
        if (drop) chk("overflow_set", a_overflow, 1);
    endtask

    task automatic drain();
        logic [7:0] head;
        for (int i = 0; i < 8 && rx_q.size() > 0; i++) begin
            head = rx_q.pop_front();
            chk("drain_a", a_rx_data, head);
            chk("drain_b", b_rx_data, head);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        chk("fifo_empty_a", a_rx_valid, 0);
        chk("fifo_empty_b", b_rx_valid, 0);
    endtask

    // Issue one read; optionally strobe a second (illegal) read one cycle
    // later, while responder A is in TURN and responder B is in DRIVE.
    task automatic do_read(input bit inject);
        int         lat_a, lat_b;
        logic [8:0] ga, gb, ea, eb;
        ea = tx_full_m ? {1'b0, tx_data_m} : 9'h100;
        rsp_qa.push_back(ea);
        rsp_qb.push_back(ea);
        tx_full_m = 1'b0;
        ga = 'x;
        gb = 'x;
        cmd_valid = 1'b1;
        cmd_rd    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        lat_a = 0;
        lat_b = 0;
        for (int c = 1; c <= 20 && (lat_a == 0 || lat_b == 0); c++) begin
            if (c > 1) begin
                tick();
                cmd_valid = 1'b0;
                cmd_rd    = 1'b0;
            end
            if (a_rsp_valid && lat_a == 0) begin
                lat_a = c;
                ga    = {a_rsp_err, dq_a};
            end else if (c == 1) begin
                chk_rel("turn_released_a", dq_a);
            end
            if (b_rsp_valid && lat_b == 0) begin
                lat_b = c;
                gb    = {b_rsp_err, dq_b};
            end
            if (inject && c == 1) begin
                cmd_valid = 1'b1;
                cmd_rd    = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        chk("latency_a", lat_a, 2);
        chk("latency_b", lat_b, 1);
        ea = rsp_qa.pop_front();
        eb = rsp_qb.pop_front();
        chk("rsp_a", ga, ea);
        chk("rsp_b", gb, eb);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rsp_valid_low_a", a_rsp_valid, 0);
            chk("rsp_valid_low_b", b_rsp_valid, 0);
            chk_rel("idle_released_a", dq_a);
            chk_rel("idle_released_b", dq_b);
        end
        chk("rsp_err_low_a", a_rsp_err, 0);
        chk("tx_ready_after_rd", a_tx_ready, 1);
        chk("proto_err_a", a_proto_err, inject);
        chk("proto_err_b", b_proto_err, inject);
        chk("ignored_cmd_no_push", a_rx_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_rsp_err", a_rsp_err, 0);
        chk("rst_rx_valid", a_rx_valid, 0);
        chk("rst_tx_ready", a_tx_ready, 1);
        chk("rst_overflow", a_overflow, 0);
        chk("rst_proto_err", a_proto_err, 0);
        chk_rel("rst_dq_a", dq_a);
        rst_n = 1'b1;
        tick();

        // Two writes, then drain in order
        chk("rx_valid_before_wr", a_rx_valid, 0);
        do_write(8'hA5, 1'b0, 1'b0);
        do_write(8'h3C, 1'b0, 1'b0);
        drain();

        // Read with a loaded TX buffer, then with it empty
        load_tx(8'h5A);
        do_read(1'b0);
        do_read(1'b0);

        // Fill, overflow with concurrent pop, clear, overflow racing a clear
        do_write(8'h11, 1'b0, 1'b0);
        do_write(8'h22, 1'b0, 1'b0);
        do_write(8'h33, 1'b0, 1'b0);
        do_write(8'h44, 1'b0, 1'b0);
        chk("no_overflow_at_full", a_overflow, 0);
        do_write(8'h55, 1'b1, 1'b0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("overflow_cleared", a_overflow, 0);
        do_write(8'h66, 1'b0, 1'b0);
        do_write(8'h77, 1'b0, 1'b1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("overflow_cleared2", a_overflow, 0);
        drain();

        // Command during TURN/DRIVE is ignored and flagged
        load_tx(8'hC3);
        do_read(1'b1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("proto_cleared", a_proto_err, 0);

        // Reset in the middle of DRIVE; TX load on the DRIVE-entry edge kept
        do_write(8'hAA, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_rd    = 1'b1;
        tick();
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        tx_valid  = 1'b0;
        chk("drive_rsp_valid", a_rsp_valid, 1);
        chk("drive_rsp_err", a_rsp_err, 1);
        chk("drive_dq_zero", dq_a, 8'h00);
        chk("load_kept", a_tx_ready, 0);
        chk("drive_proto", a_proto_err, 1);
        rst_n = 1'b0;
        #1;
        rx_q.delete();
        chk_rel("arst_dq_a", dq_a);
        chk_rel("arst_dq_b", dq_b);
        chk("arst_rsp_valid", a_rsp_valid, 0);
        chk("arst_rsp_err", a_rsp_err, 0);
        chk("arst_rx_valid", a_rx_valid, 0);
        chk("arst_tx_ready", a_tx_ready, 1);
        chk("arst_proto_err", a_proto_err, 0);
        chk("arst_overflow", a_overflow, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
